// File: rtl/mem_arbiter_if.sv
// Purpose: bundles the two requester ports and the memory port of mem_arbiter.
// Latency: none, wires only.
// Backpressure: req is held until ack; the arbiter is the only source of ack.
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  // requester 0 (fetch)
  logic          r0_req;
  logic          r0_we;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r0_ack;
  logic [DW-1:0] r0_rdata;

  // requester 1 (data)
  logic          r1_req;
  logic          r1_we;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r1_ack;
  logic [DW-1:0] r1_rdata;

  // memory side
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;

  // status
  logic          busy;

  // arbiter view
  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  mem_dout,
    output r0_ack, r0_rdata, r1_ack, r1_rdata,
    output mem_addr, mem_din, mem_we,
    output busy
  );

  // requester / memory view
  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output mem_dout,
    input  r0_ack, r0_rdata, r1_ack, r1_rdata,
    input  mem_addr, mem_din, mem_we,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: round-robin arbiter giving two requesters access to one single-port memory.
// Latency: request sampled at grant edge N, ack and rdata registered at edge N+2; one access per 3 cycles.
// Backpressure: a requester holds req until its ack pulse; an acked port is ineligible in its ack cycle.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // registered outputs
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_din_q;
  logic          mem_we_q;
  logic          r0_ack_q;
  logic          r1_ack_q;
  logic [DW-1:0] r0_rdata_q;
  logic [DW-1:0] r1_rdata_q;

  // arbitration state: 0 = r0, 1 = r1
  logic          last_grant;
  logic          gnt;

  // grant decision for the current cycle
  logic          r0_elig;
  logic          r1_elig;
  logic          grant_vld;
  logic          grant_sel;

  // A port in its ack cycle has already been served; masking it here stops
  // a still-high req from being issued twice.
  assign r0_elig = bus.r0_req & ~r0_ack_q;
  assign r1_elig = bus.r1_req & ~r1_ack_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: one cycle each in ACCESS and CAPTURE, leave IDLE only on a grant.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = ACCESS;
      ACCESS:  state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: pick the winner in IDLE; on a tie the port not served last wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_sel = 1'b0;
    if (state == IDLE) begin
      if (r0_elig && r1_elig) begin
        grant_vld = 1'b1;
        grant_sel = ~last_grant;
      end else if (r0_elig) begin
        grant_vld = 1'b1;
        grant_sel = 1'b0;
      end else if (r1_elig) begin
        grant_vld = 1'b1;
        grant_sel = 1'b1;
      end
    end
  end

  // Datapath: latch the winner's command at grant, close the write after
  // ACCESS, return mem_dout to the granted port at the end of CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      r0_ack_q   <= 1'b0;
      r1_ack_q   <= 1'b0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
    end else begin
      r0_ack_q <= 1'b0;
      r1_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            gnt        <= grant_sel;
            last_grant <= grant_sel;
            if (grant_sel) begin
              mem_addr_q <= bus.r1_addr;
              mem_din_q  <= bus.r1_wdata;
              mem_we_q   <= bus.r1_we;
            end else begin
              mem_addr_q <= bus.r0_addr;
              mem_din_q  <= bus.r0_wdata;
              mem_we_q   <= bus.r0_we;
            end
          end
        end
        ACCESS: begin
          mem_we_q <= 1'b0;
        end
        CAPTURE: begin
          if (gnt) begin
            r1_rdata_q <= bus.mem_dout;
            r1_ack_q   <= 1'b1;
          end else begin
            r0_rdata_q <= bus.mem_dout;
            r0_ack_q   <= 1'b1;
          end
        end
        default: begin
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.r0_ack   = r0_ack_q;
  assign bus.r1_ack   = r1_ack_q;
  assign bus.r0_rdata = r0_rdata_q;
  assign bus.r1_rdata = r1_rdata_q;
  assign bus.busy     = (state != IDLE);

  // The write strobe must never be visible outside ACCESS.
  a_we_only_in_access: assert property (
    @(posedge clk) disable iff (!rst_n) mem_we_q |-> (state == ACCESS)
  );

  // Only one port can complete per cycle.
  a_ack_onehot: assert property (
    @(posedge clk) disable iff (!rst_n) !(r0_ack_q && r1_ack_q)
  );

endmodule
